// File: rtl/risc_mc_core_if.sv
// Unified memory port of risc_mc_core: one req/ack handshake shared by
// instruction fetch and data access.
// Ports: mem_req/mem_we/mem_addr/mem_wdata from the core (master),
// mem_rdata/mem_ack from memory (slave).
interface risc_mc_core_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/risc_mc_core.sv
// Multicycle RISC core: FSM-sequenced datapath, 8 x DATA_W registers,
// C/Z flags, one memory port tolerant of any number of wait states.
// Ports: clk, reset (async, active-high), mem (master side of the bus),
// pc (current instruction), retire (last cycle of an instruction),
// halted (core stopped), illegal (stopped on an undefined opcode).
module risc_mc_core #(
    parameter int              DATA_W   = 16,
    parameter int              ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    risc_mc_core_if.master    mem,
    output logic [ADDR_W-1:0] pc,
    output logic              retire,
    output logic              halted,
    output logic              illegal
);
    typedef enum logic [2:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADI  = 4'b0001;
    localparam logic [3:0] OP_NDU  = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1111;

    state_t state, nxt;

    logic [15:0]       ir;
    logic [DATA_W-1:0] rf [8];
    logic [DATA_W-1:0] a_q, b_q, res_q;
    logic              res_c;
    logic              c_q, z_q;
    logic [ADDR_W-1:0] pc_q;
    logic              illegal_q;

    logic [3:0]        op;
    logic [2:0]        ra, rb, rc;
    logic [DATA_W-1:0] imm;
    logic              op_legal;
    logic              accept;
    logic [DATA_W:0]   add_sum;
    logic [DATA_W-1:0] br_sum;
    logic [ADDR_W-1:0] pc_inc, pc_br;

    assign op  = ir[15:12];
    assign ra  = ir[11:9];
    assign rb  = ir[8:6];
    assign rc  = ir[5:3];
    assign imm = {{(DATA_W-6){ir[5]}}, ir[5:0]};

    // mem_ack outside a request is ignored by construction
    assign accept = mem.mem_req && mem.mem_ack;

    // ADD uses RA+RB, ADI uses RA+imm6; carry kept in the top bit
    assign add_sum = {1'b0, a_q} + {1'b0, (op == OP_ADI) ? imm : b_q};
    assign br_sum  = DATA_W'(pc_q) + imm;
    assign pc_br   = ADDR_W'(br_sum);
    assign pc_inc  = pc_q + 1'b1;

    always_comb begin
        op_legal = 1'b0;
        unique case (op)
            OP_ADD, OP_ADI, OP_NDU,
            OP_LW, OP_SW, OP_BEQ: op_legal = 1'b1;
            default:              op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_RST;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_RST:    nxt = S_FETCH;
            S_FETCH:  if (accept) nxt = S_DECODE;
            S_DECODE: nxt = op_legal ? S_EXEC : S_HALTED;
            S_EXEC: begin
                if (op == OP_LW || op == OP_SW) nxt = S_MEM;
                else if (op == OP_BEQ)          nxt = S_FETCH;
                else                            nxt = S_WB;
            end
            S_MEM:    if (accept) nxt = (op == OP_SW) ? S_FETCH : S_WB;
            S_WB:     nxt = S_FETCH;
            S_HALTED: nxt = S_HALTED;
            default:  nxt = S_RST;
        endcase
    end

    // Bus outputs depend on state only, so they hold steady during waits
    // and drop as soon as reset forces the state back to RST.
    assign mem.mem_req   = (state == S_FETCH) || (state == S_MEM);
    assign mem.mem_we    = (state == S_MEM) && (op == OP_SW);
    assign mem.mem_addr  = (state == S_FETCH) ? pc_q :
                           (state == S_MEM)   ? ADDR_W'(res_q) : '0;
    assign mem.mem_wdata = ((state == S_MEM) && (op == OP_SW)) ? a_q : '0;

    assign retire  = (state == S_WB)
                  || ((state == S_EXEC) && (op == OP_BEQ))
                  || ((state == S_MEM) && (op == OP_SW) && accept);
    assign halted  = (state == S_HALTED);
    assign illegal = illegal_q;
    assign pc      = pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir        <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            res_c     <= 1'b0;
            c_q       <= 1'b0;
            z_q       <= 1'b0;
            pc_q      <= RESET_PC;
            illegal_q <= 1'b0;
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else begin
            unique case (state)
                S_FETCH: if (accept) ir <= mem.mem_rdata[15:0];
                S_DECODE: begin
                    a_q <= rf[ra];
                    b_q <= rf[rb];
                    if (!op_legal && op != OP_HALT) illegal_q <= 1'b1;
                end
                S_EXEC: begin
                    unique case (op)
                        OP_ADD, OP_ADI: {res_c, res_q} <= add_sum;
                        OP_NDU:         res_q <= ~(a_q & b_q);
                        OP_LW, OP_SW:   res_q <= b_q + imm;
                        OP_BEQ:         pc_q  <= (a_q == b_q) ? pc_br : pc_inc;
                        default:        ;
                    endcase
                end
                S_MEM: begin
                    if (accept) begin
                        if (op == OP_SW) pc_q  <= pc_inc;
                        else             res_q <= mem.mem_rdata;
                    end
                end
                S_WB: begin
                    pc_q <= pc_inc;
                    z_q  <= (res_q == '0);
                    unique case (op)
                        OP_ADD: begin rf[rc] <= res_q; c_q <= res_c; end
                        OP_NDU: rf[rc] <= res_q;
                        OP_ADI: begin rf[rb] <= res_q; c_q <= res_c; end
                        OP_LW:  rf[ra] <= res_q;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_risc_mc_core.sv
// Directed bench for risc_mc_core: small programs in a wait-state
// memory model, hand-computed register/flag/PC/cycle expectations.
module tb_risc_mc_core;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] pc;
    logic retire, halted, illegal;

    risc_mc_core_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    risc_mc_core #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .mem(bus.master),
        .pc(pc), .retire(retire), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [256];
    logic [15:0] wmem [256];
    int wgen [256] = '{default: 0};
    int test_id = 0;
    int fw = 0;
    int mw = 0;
    int cnt = 0;
    logic is_fetch;

    assign is_fetch = !bus.mem_we && (bus.mem_addr == pc);
    assign bus.mem_ack = bus.mem_req && (cnt >= (is_fetch ? fw : mw));
    assign bus.mem_rdata = (wgen[bus.mem_addr[7:0]] == test_id) ?
                           wmem[bus.mem_addr[7:0]] : rom[bus.mem_addr[7:0]];

    always @(posedge clk or posedge reset) begin
        if (reset) cnt <= 0;
        else if (!bus.mem_req || bus.mem_ack) cnt <= 0;
        else cnt <= cnt + 1;
    end

    always @(posedge clk) begin
        if (bus.mem_req && bus.mem_ack && bus.mem_we) begin
            wmem[bus.mem_addr[7:0]] <= bus.mem_wdata;
            wgen[bus.mem_addr[7:0]] <= test_id;
        end
    end

    int rcnt = 0, wecyc = 0, lw4 = 0, f0 = 0, ff = 0, reqcyc = 0, viol = 0;
    logic p_wait = 1'b0;
    logic p_we;
    logic [15:0] p_addr, p_wd;

    always @(negedge clk) begin
        if (reset) begin
            p_wait <= 1'b0;
        end else begin
            if (p_wait && !(bus.mem_req && bus.mem_addr == p_addr &&
                            bus.mem_we == p_we && bus.mem_wdata == p_wd))
                viol <= viol + 1;
            if (bus.mem_we && !bus.mem_req) viol <= viol + 1;
            p_wait <= bus.mem_req && !bus.mem_ack;
            p_addr <= bus.mem_addr;
            p_we   <= bus.mem_we;
            p_wd   <= bus.mem_wdata;
            if (retire) rcnt <= rcnt + 1;
            if (bus.mem_req) reqcyc <= reqcyc + 1;
            if (bus.mem_req && bus.mem_we) wecyc <= wecyc + 1;
            if (bus.mem_req && !bus.mem_we && bus.mem_addr == 16'h0004)
                lw4 <= lw4 + 1;
            if (bus.mem_req && bus.mem_ack && !bus.mem_we) begin
                if (bus.mem_addr == 16'h0000) f0 <= f0 + 1;
                if (bus.mem_addr == 16'hFFFF) ff <= ff + 1;
            end
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_test();
        test_id++;
        for (int i = 0; i < 256; i++) rom[i] = 16'h7000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic run(input string tag, input int bound, output int n);
        n = 0;
        while (!halted && n < bound) begin
            @(posedge clk);
            #1 n++;
        end
        check({tag, "_halted"}, 32'(halted), 32'd1);
    endtask

    int n, s0, s1, s2, s3;

    initial begin
        // reset state
        new_test();
        #2;
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_flags", {29'd0, retire, halted, illegal}, 32'd0);

        // zero-wait ALU: R1=5, R2=7, R3=R1+R2
        new_test();
        rom[0] = 16'h1045; rom[1] = 16'h1087;
        rom[2] = 16'h0298; rom[3] = 16'hF000;
        s0 = rcnt;
        do_reset();
        run("alu", 100, n);
        check("alu_cycles", 32'(n), 32'd15);
        check("alu_r3", 32'(dut.rf[3]), 32'd12);
        check("alu_cz", {30'd0, dut.c_q, dut.z_q}, 32'd0);
        check("alu_retires", 32'(rcnt - s0), 32'd3);

        // carry/zero: 0xFFFF + 1
        new_test();
        rom[0] = 16'h107F; rom[1] = 16'h1081;
        rom[2] = 16'h0298; rom[3] = 16'hF000;
        do_reset();
        run("carry", 100, n);
        check("carry_r3", 32'(dut.rf[3]), 32'd0);
        check("carry_cz", {30'd0, dut.c_q, dut.z_q}, 32'd3);

        // wait states: fetch 3, data 2; LW R4 <- M[R1-1]
        new_test();
        fw = 3; mw = 2;
        rom[0] = 16'h1045; rom[1] = 16'h487F;
        rom[2] = 16'hF000; rom[4] = 16'hBEEF;
        s0 = lw4; s1 = viol;
        do_reset();
        run("lw", 200, n);
        check("lw_cycles", 32'(n), 32'd23);
        check("lw_r4", 32'(dut.rf[4]), 32'hBEEF);
        check("lw_z", 32'(dut.z_q), 32'd0);
        check("lw_mem_cycles", 32'(lw4 - s0), 32'd3);
        check("lw_stable", 32'(viol - s1), 32'd0);
        fw = 0; mw = 0;

        // SW then LW round trip through M[10]
        new_test();
        rom[0] = 16'h1045; rom[1] = 16'h1087; rom[2] = 16'h0298;
        rom[3] = 16'h560A; rom[4] = 16'h4A0A; rom[5] = 16'hF000;
        s0 = wecyc; s1 = viol;
        do_reset();
        run("sw", 200, n);
        check("sw_mem10", 32'(wmem[10]), 32'd12);
        check("sw_r5", 32'(dut.rf[5]), 32'd12);
        check("sw_z", 32'(dut.z_q), 32'd0);
        check("sw_we_cycles", 32'(wecyc - s0), 32'd1);
        check("sw_bus", 32'(viol - s1), 32'd0);

        // BEQ taken, imm -2 at PC 20
        new_test();
        rom[0] = 16'hC014; rom[20] = 16'hC03E; rom[18] = 16'hF000;
        do_reset();
        run("beq_t", 100, n);
        check("beq_t_cycles", 32'(n), 32'd9);
        check("beq_t_pc", 32'(pc), 32'd18);

        // BEQ not taken at PC 20
        new_test();
        rom[0] = 16'h1045; rom[1] = 16'hC013;
        rom[20] = 16'hC07E; rom[21] = 16'hF000;
        do_reset();
        run("beq_n", 100, n);
        check("beq_n_pc", 32'(pc), 32'd21);
        check("beq_n_ill", 32'(illegal), 32'd0);

        // PC wrap 0xFFFF -> 0
        new_test();
        rom[0] = 16'hC23F; rom[255] = 16'h1045; rom[1] = 16'hF000;
        s0 = f0; s1 = ff;
        do_reset();
        run("wrap", 100, n);
        check("wrap_pc", 32'(pc), 32'd1);
        check("wrap_r1", 32'(dut.rf[1]), 32'd5);
        check("wrap_f0", 32'(f0 - s0), 32'd2);
        check("wrap_fffff", 32'(ff - s1), 32'd1);

        // HALT: stays quiet on the bus
        new_test();
        rom[0] = 16'hF000;
        do_reset();
        run("halt", 50, n);
        check("halt_cycles", 32'(n), 32'd3);
        check("halt_ill", 32'(illegal), 32'd0);
        s2 = reqcyc;
        repeat (20) @(posedge clk);
        #1 check("halt_noreq", 32'(reqcyc - s2), 32'd0);

        // illegal opcode 0111
        new_test();
        rom[0] = 16'h1045; rom[1] = 16'h7000;
        do_reset();
        run("ill", 50, n);
        check("ill_flag", 32'(illegal), 32'd1);
        check("ill_r1", 32'(dut.rf[1]), 32'd5);
        check("ill_r0", 32'(dut.rf[0]), 32'd0);
        check("ill_pc", 32'(pc), 32'd1);

        // reset mid-fetch with ack withheld
        new_test();
        rom[0] = 16'h1045; rom[1] = 16'hF000;
        do_reset();
        run("pre", 50, n);
        fw = 1000;
        do_reset();
        repeat (3) @(posedge clk);
        #1 check("mid_req_held", 32'(bus.mem_req), 32'd1);
        #2 reset = 1'b1;
        #1 check("mid_req_drop", 32'(bus.mem_req), 32'd0);
        check("mid_r1", 32'(dut.rf[1]), 32'd0);
        fw = 0;
        @(negedge clk);
        #1 reset = 1'b0;
        #1 check("mid_rst_state", 32'(bus.mem_req), 32'd0);
        @(posedge clk);
        #1 check("mid_fetch", {15'd0, bus.mem_req, bus.mem_addr}, 32'h10000);
        check("mid_halted", 32'(halted), 32'd0);
        s3 = 0;
        run("post", 50, n);
        check("post_r1", 32'(dut.rf[1]), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
